// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill sequencer.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    FILL = 2'b10
  } fill_state_t;

  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned BLK_OFF_W     = 4;
  localparam int unsigned WORD_SEL_W    = 3;

  // Byte address of a 16-bit word within a block.
  function automatic logic [15:0] word_addr(input logic [15-BLK_OFF_W:0] blk,
                                            input logic [WORD_SEL_W-1:0] idx);
    return {blk, idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_word_cnt.sv
// 4-bit word counter with synchronous clear and increment, asynchronous reset.
module fill_word_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill sequencer: requests memory, streams one block as pipelined word reads, writes
// data and tag. Optional counters under `CACHE_FILL_PERF_EN (miss_count, stall_cycles).
module cache_fill_ctrl #(
  parameter int unsigned WORDS_PER_BLK = cache_pkg::WORDS_PER_BLK,
  parameter int unsigned MEM_LAT       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        mem_gnt,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic        filling,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [2:0]  data_word_sel,
  output logic [15:0] data_out,
`ifdef CACHE_FILL_PERF_EN
  output logic [15:0] miss_count,
  output logic [15:0] stall_cycles,
`endif
  output logic        fill_done
);

  import cache_pkg::*;

  // Counter and word-select widths are fixed; the FSM counts valids, not latency.
  if (WORDS_PER_BLK != (1 << WORD_SEL_W) || MEM_LAT == 0) begin : g_bad_cfg
    $error("cache_fill_ctrl: unsupported WORDS_PER_BLK or MEM_LAT");
  end

  localparam logic [3:0] BlkWords = 4'(WORDS_PER_BLK);
  localparam logic [3:0] LastWord = 4'(WORDS_PER_BLK - 1);

  fill_state_t              state;
  logic [15-BLK_OFF_W:0]    blk_addr;
  logic                     busy_q;
  logic [3:0]               issue_cnt;
  logic [3:0]               ret_cnt;
  logic                     cnt_clr;
  logic                     do_issue;
  logic                     do_ret;
  logic                     last_ret;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^miss_address[BLK_OFF_W-1:0];

  assign cnt_clr  = (state == IDLE) && miss_detected;
  assign do_issue = (state == FILL) && mem_gnt && (issue_cnt < BlkWords);
  // A valid with nothing outstanding is spurious and must not advance ret_cnt.
  assign do_ret   = (state == FILL) && mem_data_valid && (ret_cnt < issue_cnt);
  assign last_ret = do_ret && (ret_cnt == LastWord);

  fill_word_cnt u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (do_issue),
    .count (issue_cnt)
  );

  fill_word_cnt u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (do_ret),
    .count (ret_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      blk_addr <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_detected) begin
            blk_addr <= miss_address[15:BLK_OFF_W];
            state    <= REQ;
            busy_q   <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (last_ret) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign filling          = busy_q;
  assign fsm_busy         = busy_q;
  assign mem_en           = do_issue;
  assign mem_wr           = 1'b0;
  assign mem_address      = do_issue ? word_addr(blk_addr, issue_cnt[WORD_SEL_W-1:0]) : 16'h0000;
  assign write_data_array = do_ret;
  assign data_word_sel    = do_ret ? ret_cnt[WORD_SEL_W-1:0] : 3'd0;
  assign write_tag_array  = last_ret;
  assign fill_done        = last_ret;
  assign data_out         = mem_data;

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count   <= 16'h0000;
      stall_cycles <= 16'h0000;
    end else begin
      if (cnt_clr && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
      if (busy_q && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: behavioural fill model, latency-4 memory
// responder, and directed scenarios with literal expectations.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_gnt;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        filling;
  logic        fsm_busy;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  data_word_sel;
  logic [15:0] data_out;
  logic        fill_done;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] miss_count;
  logic [15:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int en_total = 0;
  int wr_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_gnt          (mem_gnt),
    .mem_data         (mem_data),
    .mem_data_valid   (mem_data_valid),
    .filling          (filling),
    .fsm_busy         (fsm_busy),
    .mem_en           (mem_en),
    .mem_wr           (mem_wr),
    .mem_address      (mem_address),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .data_word_sel    (data_word_sel),
    .data_out         (data_out),
`ifdef CACHE_FILL_PERF_EN
    .miss_count       (miss_count),
    .stall_cycles     (stall_cycles),
`endif
    .fill_done        (fill_done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: each read returns addr^5A5A exactly four cycles after it was issued.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;
  rd_t         pend[$];
  logic        resp_valid = 1'b0;
  logic [15:0] resp_data  = 16'h0000;
  logic        spur       = 1'b0;

  assign mem_data_valid = resp_valid | spur;
  assign mem_data       = resp_valid ? resp_data : 16'hDEAD;

  always @(negedge clk) begin
    if (rst === 1'b0 && mem_en === 1'b1) pend.push_back('{mem_address, cyc + 4});
  end

  always @(posedge clk) begin
    #1;
    resp_valid = 1'b0;
    resp_data  = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      resp_valid = 1'b1;
      resp_data  = pend[0].addr ^ 16'h5A5A;
      void'(pend.pop_front());
    end
  end

  // Fill model: phase 0 idle, 1 awaiting grant, 2 owning memory.
  int m_phase = 0;
  int m_blk   = 0;
  int m_issued = 0;
  int m_ret   = 0;

  always @(negedge clk) begin
    logic        e_en;
    logic        e_wda;
    logic        e_last;
    logic        e_busy;
    logic [15:0] e_addr;
    logic [2:0]  e_sel;
    e_en = 1'b0; e_wda = 1'b0; e_last = 1'b0; e_addr = 16'h0000; e_sel = 3'd0;
    if (rst) begin
      m_phase = 0; m_issued = 0; m_ret = 0;
    end
    e_busy = (m_phase != 0);
    if (!rst && m_phase == 2) begin
      if (mem_gnt && m_issued < 8) begin
        e_en   = 1'b1;
        e_addr = 16'(m_blk * 16 + m_issued * 2);
      end
      if (mem_data_valid && m_ret < m_issued) begin
        e_wda  = 1'b1;
        e_sel  = 3'(m_ret);
        e_last = (m_ret == 7);
      end
    end
    chk("filling", filling, e_busy);
    chk("fsm_busy", fsm_busy, e_busy);
    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, 1'b0);
    chk("mem_address", mem_address, e_addr);
    chk("write_data_array", write_data_array, e_wda);
    chk("data_word_sel", data_word_sel, e_sel);
    chk("write_tag_array", write_tag_array, e_last);
    chk("fill_done", fill_done, e_last);
    chk("data_out", data_out, mem_data);
    if (e_wda) chk("word_data", data_out, 16'(m_blk * 16 + m_ret * 2) ^ 16'h5A5A);
    if (mem_en === 1'b1) en_total++;
    if (write_data_array === 1'b1) wr_total++;
    if (!rst) begin
      case (m_phase)
        0: if (miss_detected) begin
             m_phase = 1; m_blk = int'(miss_address[15:4]); m_issued = 0; m_ret = 0;
           end
        1: if (mem_gnt) m_phase = 2;
        default: begin
          m_issued += int'(e_en);
          m_ret    += int'(e_wda);
          if (e_last) m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (fsm_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", fsm_busy, 1'b0);
  endtask

  // Miss in cycle 0 with grant held high; returns at the start of cycle 14.
  task automatic nominal(input logic [15:0] addr);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    miss_detected = 1'b1;
    miss_address  = addr;
    mem_gnt       = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) chk("nom_idle_at_miss", fsm_busy, 1'b0);
      if (k == 1) begin
        chk("nom_req_busy", fsm_busy, 1'b1);
        chk("nom_req_no_en", mem_en, 1'b0);
      end
      if (k >= 2 && k <= 9) begin
        chk("nom_issue_en", mem_en, 1'b1);
        chk("nom_issue_addr", mem_address, base + 16'(2 * (k - 2)));
      end
      if (k >= 10) chk("nom_issue_stop", mem_en, 1'b0);
      if (k >= 6) begin
        chk("nom_write", write_data_array, 1'b1);
        chk("nom_write_sel", {13'd0, data_word_sel}, 16'(k - 6));
      end
      chk("nom_tag", write_tag_array, 1'(k == 13));
      chk("nom_done", fill_done, 1'(k == 13));
      tick();
      // A miss while busy must be ignored.
      miss_detected = (k == 3);
      miss_address  = 16'hBEEF;
    end
    miss_detected = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0;
    int wr0;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    mem_gnt       = 1'b0;
    #1;
    chk("rst_filling", filling, 1'b0);
    chk("rst_busy", fsm_busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_wda", write_data_array, 1'b0);
    chk("rst_tag", write_tag_array, 1'b0);
    chk("rst_done", fill_done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Spurious valid while idle.
    spur = 1'b1;
    @(negedge clk);
    chk("spur_idle_no_write", write_data_array, 1'b0);
    tick();
    spur = 1'b0;

    nominal(16'h1236);
    nominal(16'h4BEE);
    // Spurious valid right after the final word.
    spur = 1'b1;
    @(negedge clk);
    chk("spur_after_no_write", write_data_array, 1'b0);
    chk("after_fill_idle", fsm_busy, 1'b0);
    tick();
    spur = 1'b0;
`ifdef CACHE_FILL_PERF_EN
    chk("perf_miss_count", miss_count, 16'd2);
    chk("perf_stall_cycles", stall_cycles, 16'd26);
`endif

    // Grant withheld for 5 cycles in REQ, with a spurious valid thrown in.
    mem_gnt = 1'b0;
    miss_detected = 1'b1;
    miss_address  = 16'h7770;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 5; k++) begin
      spur = (k == 2);
      @(negedge clk);
      chk("nogrant_filling", filling, 1'b1);
      chk("nogrant_no_en", mem_en, 1'b0);
      tick();
    end
    spur = 1'b0;
    mem_gnt = 1'b1;
    wait_idle(40);

    // Grant dropped for 4 cycles after 3 issues.
    en0 = en_total;
    wr0 = wr_total;
    miss_detected = 1'b1;
    miss_address  = 16'hC0DA;
    for (int k = 1; k <= 5; k++) begin
      tick();
      miss_detected = 1'b0;
    end
    mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    mem_gnt = 1'b1;
    wait_idle(40);
    chk("drop_en_pulses", 16'(en_total - en0), 16'd8);
    chk("drop_writes", 16'(wr_total - wr0), 16'd8);

    // Reset in cycle 8 of a fill.
    miss_detected = 1'b1;
    miss_address  = 16'h3A50;
    for (int k = 1; k <= 8; k++) begin
      tick();
      miss_detected = 1'b0;
    end
    wr0 = wr_total;
    rst = 1'b1;
    #1;
    chk("midrst_filling", filling, 1'b0);
    chk("midrst_busy", fsm_busy, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_addr", mem_address, 16'h0000);
    chk("midrst_wda", write_data_array, 1'b0);
    chk("midrst_tag", write_tag_array, 1'b0);
    chk("midrst_done", fill_done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("midrst_late_valids_ignored", 16'(wr_total - wr0), 16'd0);
    nominal(16'h9E44);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
